// File: rtl/cb_cfg_loader.sv
`default_nettype none
// ============================================================================
// cb_cfg_loader: serializes host config words LSB-first onto the CB chain,
// framed by prgm_b, and checks that the enable token comes back.
// Rev 1.0
// ============================================================================
module cb_cfg_loader #(
  parameter int WORD_W      = 8,
  parameter int CHAIN_LEN   = 48,
  parameter int NUM_CB      = 4,
  parameter int TOK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              bit_out,
  output logic              cb_prgm_b,
  output logic              prgm_b,
  output logic              tok_out,
  input  logic              tok_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        bit_count
);

  localparam int c_total = NUM_CB * CHAIN_LEN;
  localparam int c_sub_w = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int c_tmo_w = $clog2(TOK_TIMEOUT + 1);

  localparam logic [c_sub_w-1:0] c_sub_last = c_sub_w'(WORD_W - 1);
  localparam logic [7:0]         c_cnt_last = 8'(c_total - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TOK_TIMEOUT - 1);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_fetch = 3'd1;
  localparam logic [2:0] c_st_shift = 3'd2;
  localparam logic [2:0] c_st_check = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [WORD_W-1:0]  r_shreg;
  logic [c_sub_w-1:0] r_sub_cnt;
  logic [7:0]         r_bit_count;
  logic [c_tmo_w-1:0] r_tmo;
  logic               r_tok_seen;
  logic               r_tok_out;
  logic               r_done;
  logic               r_err;

  logic w_idle_like;
  logic w_accept_start;
  logic w_active;
  logic w_last_bit;
  logic w_last_total;
  logic w_tok_hit;

  assign w_idle_like    = (r_state == c_st_idle) || (r_state == c_st_done);
  assign w_accept_start = w_idle_like && start;
  assign w_active       = (r_state == c_st_fetch) || (r_state == c_st_shift) ||
                          (r_state == c_st_check);
  // A word ends early when the chain is full; leftover high bits are dropped.
  assign w_last_total   = (r_bit_count == c_cnt_last);
  assign w_last_bit     = (r_sub_cnt == c_sub_last) || w_last_total;
  assign w_tok_hit      = r_tok_seen || tok_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle, c_st_done: begin
        if (start) w_state_nxt = c_st_fetch;
      end
      c_st_fetch: begin
        if (word_valid) w_state_nxt = c_st_shift;
      end
      c_st_shift: begin
        if (w_last_bit) w_state_nxt = w_last_total ? c_st_check : c_st_fetch;
      end
      c_st_check: begin
        if (w_tok_hit || (r_tmo == c_tmo_last)) w_state_nxt = c_st_done;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    word_ready = 1'b0;
    cb_prgm_b  = 1'b0;
    bit_out    = 1'b0;
    prgm_b     = w_active;
    busy       = w_active;
    case (r_state)
      c_st_fetch: word_ready = 1'b1;
      c_st_shift: begin
        cb_prgm_b = 1'b1;
        bit_out   = r_shreg[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg     <= '0;
      r_sub_cnt   <= '0;
      r_bit_count <= '0;
      r_tmo       <= '0;
      r_tok_seen  <= 1'b0;
      r_tok_out   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_tok_out <= 1'b0;
      if (w_accept_start) begin
        r_tok_out   <= 1'b1;
        r_done      <= 1'b0;
        r_err       <= 1'b0;
        r_bit_count <= '0;
        r_tok_seen  <= 1'b0;
      end
      // Token may return at any point once the load is under way.
      if (w_active && tok_in) begin
        r_tok_seen <= 1'b1;
      end
      if ((r_state == c_st_fetch) && word_valid) begin
        r_shreg   <= word_in;
        r_sub_cnt <= '0;
      end
      if (r_state == c_st_shift) begin
        r_shreg     <= r_shreg >> 1;
        r_sub_cnt   <= r_sub_cnt + 1'b1;
        r_bit_count <= r_bit_count + 1'b1;
        r_tmo       <= '0;
      end
      if (r_state == c_st_check) begin
        r_tmo <= r_tmo + 1'b1;
        if (w_tok_hit) begin
          r_done <= 1'b1;
        end else if (r_tmo == c_tmo_last) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign tok_out   = r_tok_out;
  assign done      = r_done;
  assign err       = r_err;
  assign bit_count = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_cb_cfg_loader.sv
`default_nettype none
// ============================================================================
// tb_cb_cfg_loader: directed-vector bench for cb_cfg_loader (full-size and
// a 12-bit single-CB instance).
// Rev 1.0
// ============================================================================
module tb_cb_cfg_loader;

  logic clk;
  logic reset;
  logic start, word_valid, tok_in;
  logic [7:0] word_in;
  logic word_ready, bit_out, cb_prgm_b, prgm_b, tok_out, busy, done, err;
  logic [7:0] bit_count;

  logic start_s, word_valid_s, tok_in_s;
  logic [7:0] word_in_s;
  logic word_ready_s, bit_out_s, cb_prgm_b_s, prgm_b_s, tok_out_s, busy_s, done_s, err_s;
  logic [7:0] bit_count_s;

  int n_total = 0;
  int n_bad   = 0;
  bit tok_en  = 1'b0;

  bit  q[$];
  bit  q_s[$];
  int  tok_cnt   = 0;
  int  prgm_bad  = 0;
  time t_tok     = 0;
  time t192      = 0;
  logic [7:0] prev_bc = 8'd0;

  cb_cfg_loader #(.WORD_W(8), .CHAIN_LEN(48), .NUM_CB(4), .TOK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready), .bit_out(bit_out),
    .cb_prgm_b(cb_prgm_b), .prgm_b(prgm_b), .tok_out(tok_out), .tok_in(tok_in),
    .busy(busy), .done(done), .err(err), .bit_count(bit_count)
  );

  cb_cfg_loader #(.WORD_W(8), .CHAIN_LEN(12), .NUM_CB(1), .TOK_TIMEOUT(16)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .word_in(word_in_s),
    .word_valid(word_valid_s), .word_ready(word_ready_s), .bit_out(bit_out_s),
    .cb_prgm_b(cb_prgm_b_s), .prgm_b(prgm_b_s), .tok_out(tok_out_s), .tok_in(tok_in_s),
    .busy(busy_s), .done(done_s), .err(err_s), .bit_count(bit_count_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // Serial capture and framing observations, sampled on the falling edge.
  always @(negedge clk) begin
    if (cb_prgm_b) q.push_back(bit_out);
    if ((cb_prgm_b || word_ready) && !prgm_b) prgm_bad++;
    if (tok_out) begin
      tok_cnt++;
      t_tok = $time;
    end
    if (bit_count == 8'd192 && prev_bc != 8'd192) t192 = $time;
    prev_bc = bit_count;
    if (cb_prgm_b_s) q_s.push_back(bit_out_s);
  end

  // Returns the token four cycles after the loader issues it.
  initial begin
    tok_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tok_en && tok_out) begin
        repeat (4) @(posedge clk);
        #1 tok_in = 1'b1;
        @(posedge clk);
        #1 tok_in = 1'b0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_stream(input string tag, input int base);
    int nbits_bad;
    logic [7:0] pat;
    pat = 8'hA5;
    nbits_bad = 0;
    check_val({tag, "_len"}, q.size() - base, 192);
    for (int i = 0; i < 192 && (base + i) < q.size(); i++)
      if (q[base + i] !== pat[i % 8]) nbits_bad++;
    check_val({tag, "_bits_bad"}, nbits_bad, 0);
  endtask

  task automatic run_load(input int stall_word, input int abort_at, input bit extra_start,
                          output bit aborted);
    int g;
    aborted = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int w = 0; w < 24; w++) begin
      g = 0;
      while (!word_ready && g < 64) begin
        if (abort_at >= 0 && bit_count == 8'(abort_at)) begin
          aborted = 1'b1;
          return;
        end
        start = (extra_start && bit_count == 8'd20);
        @(posedge clk); #1;
        g++;
      end
      start = 1'b0;
      if (!word_ready) begin
        check_val("fetch_timeout", 0, 1);
        return;
      end
      if (w == stall_word) begin
        for (int s = 0; s < 5; s++) begin
          check_val("stall_cb_prgm_b", cb_prgm_b, 0);
          check_val("stall_bit_count", bit_count, 32'(stall_word * 8));
          @(posedge clk); #1;
        end
      end
      word_in = 8'hA5;
      word_valid = 1'b1;
      @(posedge clk); #1;
      word_valid = 1'b0;
    end
  endtask

  task automatic wait_finish(input string tag);
    int g;
    g = 0;
    while (!(done || err) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!(done || err)) check_val({tag, "_finish_timeout"}, 0, 1);
  endtask

  initial begin
    bit ab;
    int qb, tb, bb, k, g, ones;
    logic [7:0] w_s;

    reset = 1'b1; start = 1'b0; word_in = 8'd0; word_valid = 1'b0;
    start_s = 1'b0; word_in_s = 8'd0; word_valid_s = 1'b0; tok_in_s = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_val("rst_word_ready", word_ready, 0);
    check_val("rst_bit_out",    bit_out,    0);
    check_val("rst_cb_prgm_b",  cb_prgm_b,  0);
    check_val("rst_prgm_b",     prgm_b,     0);
    check_val("rst_tok_out",    tok_out,    0);
    check_val("rst_busy",       busy,       0);
    check_val("rst_done",       done,       0);
    check_val("rst_err",        err,        0);
    check_val("rst_bit_count",  bit_count,  0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Full load, no stalls, token returned.
    tok_en = 1'b1;
    qb = q.size(); tb = tok_cnt; bb = prgm_bad;
    run_load(-1, -1, 1'b0, ab);
    wait_finish("t1");
    check_val("t1_done", done, 1);
    check_val("t1_err", err, 0);
    check_val("t1_bit_count", bit_count, 192);
    check_stream("t1_stream", qb);
    check_val("t1_prgm_b_gap", prgm_bad - bb, 0);
    check_val("t1_tok_pulses", tok_cnt - tb, 1);
    check_val("t1_cycles", 32'((t192 - t_tok) / 10), 216);
    check_val("t1_prgm_b_after", prgm_b, 0);
    check_val("t1_busy_after", busy, 0);
    repeat (3) @(posedge clk); #1;
    check_val("t1_done_sticky", done, 1);

    // Host stall before the tenth word.
    qb = q.size(); bb = prgm_bad;
    run_load(9, -1, 1'b0, ab);
    wait_finish("t2");
    check_val("t2_done", done, 1);
    check_val("t2_bit_count", bit_count, 192);
    check_stream("t2_stream", qb);
    check_val("t2_prgm_b_gap", prgm_bad - bb, 0);

    // No token: error after the timeout.
    tok_en = 1'b0;
    run_load(-1, -1, 1'b0, ab);
    g = 0;
    while (bit_count != 8'd192 && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check_val("t3_reach_check", bit_count, 192);
    check_val("t3_prgm_b_in_check", prgm_b, 1);
    k = 0;
    while (!err && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("t3_err_delay", k, 16);
    check_val("t3_err", err, 1);
    check_val("t3_done", done, 0);
    check_val("t3_prgm_b_drop", prgm_b, 0);
    check_val("t3_busy", busy, 0);

    // Extra start during SHIFT is ignored.
    tok_en = 1'b1;
    qb = q.size(); tb = tok_cnt;
    run_load(-1, -1, 1'b1, ab);
    check_val("t6_busy", busy, 1);
    wait_finish("t6");
    check_val("t6_done", done, 1);
    check_val("t6_err", err, 0);
    check_val("t6_tok_pulses", tok_cnt - tb, 1);
    check_stream("t6_stream", qb);

    // Reset in the middle of a load, then a clean reload.
    run_load(-1, 50, 1'b0, ab);
    check_val("t5_abort_hit", ab, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("t5_prgm_b", prgm_b, 0);
    check_val("t5_cb_prgm_b", cb_prgm_b, 0);
    check_val("t5_busy", busy, 0);
    check_val("t5_bit_count", bit_count, 0);
    check_val("t5_done", done, 0);
    check_val("t5_err", err, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    qb = q.size();
    run_load(-1, -1, 1'b0, ab);
    wait_finish("t5b");
    check_val("t5b_done", done, 1);
    check_val("t5b_bit_count", bit_count, 192);
    check_stream("t5b_stream", qb);

    // Single-CB 12-bit chain: second word truncated.
    qb = q_s.size();
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int w = 0; w < 2; w++) begin
      g = 0;
      while (!word_ready_s && g < 32) begin
        @(posedge clk); #1;
        g++;
      end
      check_val("t4_fetch", word_ready_s, 1);
      w_s = (w == 0) ? 8'hFF : 8'h0F;
      word_in_s = w_s;
      word_valid_s = 1'b1;
      @(posedge clk); #1;
      word_valid_s = 1'b0;
      if (w == 0) begin
        tok_in_s = 1'b1;
        @(posedge clk); #1;
        tok_in_s = 1'b0;
      end
    end
    g = 0;
    while (!(done_s || err_s) && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check_val("t4_done", done_s, 1);
    check_val("t4_err", err_s, 0);
    check_val("t4_bit_count", bit_count_s, 12);
    check_val("t4_len", q_s.size() - qb, 12);
    ones = 0;
    for (int i = qb; i < q_s.size(); i++) if (q_s[i]) ones++;
    check_val("t4_ones", ones, 12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
